// File: rtl/apb_completer_pkg.sv
// Shared types for the APB completer: FSM state encoding, captured request, alignment helper.
`ifndef DEFAULT_ADDR_WIDTH
`define DEFAULT_ADDR_WIDTH 32
`endif
`ifndef DEFAULT_DATA_WIDTH
`define DEFAULT_DATA_WIDTH 32
`endif

package apb_completer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The capture struct is sized by the build-wide defaults; the top only
  // accepts widths that fit inside it.
  localparam int CAP_ADDR_W = `DEFAULT_ADDR_WIDTH;
  localparam int CAP_DATA_W = `DEFAULT_DATA_WIDTH;
  localparam int CAP_STRB_W = CAP_DATA_W / 8;

  typedef struct packed {
    logic                  we;
    logic [CAP_ADDR_W-1:0] addr;
    logic [CAP_DATA_W-1:0] wdata;
    logic [CAP_STRB_W-1:0] be;
  } req_cap_t;

  function automatic int align_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_completer_if.sv
// APB completer bus bundle: APB side, register side and a debug view of the FSM state.
`ifndef DEFAULT_ADDR_WIDTH
`define DEFAULT_ADDR_WIDTH 32
`endif
`ifndef DEFAULT_DATA_WIDTH
`define DEFAULT_DATA_WIDTH 32
`endif

interface apb_completer_if
  import apb_completer_pkg::*;
#(
  parameter int ADDR_WIDTH = `DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = `DEFAULT_DATA_WIDTH
);
  // Handshakes: an APB transfer completes on the rising edge where
  // psel_i & penable_i & pready_o are all 1. The register side is a
  // valid/ready pair where req_o is the valid and rsp_valid_i the ready;
  // req_o and its payload (we_o/addr_o/wdata_o/be_o) stay stable until the
  // edge that samples rsp_valid_i=1, and rsp_valid_i is ignored while req_o=0.
  logic                    psel_i;
  logic                    penable_i;
  logic [ADDR_WIDTH-1:0]   paddr_i;
  logic                    pwrite_i;
  logic [DATA_WIDTH-1:0]   pwdata_i;
  logic [DATA_WIDTH/8-1:0] pstrb_i;
  logic                    pready_o;
  logic [DATA_WIDTH-1:0]   prdata_o;
  logic                    pslverr_o;
  logic                    req_o;
  logic                    we_o;
  logic [ADDR_WIDTH-1:0]   addr_o;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic [DATA_WIDTH/8-1:0] be_o;
  logic                    rsp_valid_i;
  logic [DATA_WIDTH-1:0]   rdata_i;
  logic                    err_i;
  state_t                  dbg_state;

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    input  rsp_valid_i, rdata_i, err_i,
    output pready_o, prdata_o, pslverr_o,
    output req_o, we_o, addr_o, wdata_o, be_o,
    output dbg_state
  );

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, pstrb_i,
    output rsp_valid_i, rdata_i, err_i,
    input  pready_o, prdata_o, pslverr_o,
    input  req_o, we_o, addr_o, wdata_o, be_o,
    input  dbg_state
  );

endinterface

// File: rtl/apb_completer.sv
// APB3/APB4 completer turning APB transfers into a single-outstanding register request.
// Optional request timeout is enabled by defining APB_COMPLETER_TIMEOUT_EN.
`ifndef DEFAULT_ADDR_WIDTH
`define DEFAULT_ADDR_WIDTH 32
`endif
`ifndef DEFAULT_DATA_WIDTH
`define DEFAULT_DATA_WIDTH 32
`endif

module apb_completer
  import apb_completer_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = `DEFAULT_ADDR_WIDTH,
  parameter int                  DATA_WIDTH     = `DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH:0] MAP_SIZE       = 'h100,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  apb_completer_if.slave bus
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int ALIGN_W = align_lsb(DATA_WIDTH);
  localparam int LIM_W   = ADDR_WIDTH + 2;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("apb_completer: DATA_WIDTH must be 32 or 64");
  end
  if (ADDR_WIDTH > CAP_ADDR_W || DATA_WIDTH > CAP_DATA_W) begin : g_bad_cap_width
    $error("apb_completer: widths exceed the capture struct");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_completer: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state;
  state_t                state_next;
  req_cap_t              cap;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  slverr_q;
  logic                  abort_q;

  logic                  setup;
  logic                  in_window;
  logic                  aligned;
  logic                  accept;
  logic                  aborting;
  logic                  timeout;
  logic [ADDR_WIDTH-1:0] offset;
  logic [LIM_W-1:0]      addr_ext;
  logic [LIM_W-1:0]      lo_ext;
  logic [LIM_W-1:0]      hi_ext;

  // Window bounds are compared two bits wider than the address so neither
  // BASE_ADDR+MAP_SIZE nor a high paddr can wrap into a false hit.
  assign addr_ext  = LIM_W'(bus.paddr_i);
  assign lo_ext    = LIM_W'(BASE_ADDR);
  assign hi_ext    = LIM_W'(BASE_ADDR) + LIM_W'(MAP_SIZE);
  assign in_window = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
  assign aligned   = (bus.paddr_i[ALIGN_W-1:0] == '0);
  assign accept    = in_window && aligned;
  assign offset    = bus.paddr_i - BASE_ADDR;
  assign setup     = bus.psel_i && !bus.penable_i;
  assign aborting  = abort_q || !bus.psel_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (setup) state_next = accept ? REQ : RESP;
      REQ:  if (bus.rsp_valid_i || timeout) state_next = aborting ? IDLE : RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cap      <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (setup) begin
            cap.we    <= bus.pwrite_i;
            cap.addr  <= CAP_ADDR_W'(offset);
            cap.wdata <= CAP_DATA_W'(bus.pwdata_i);
            cap.be    <= bus.pwrite_i ? CAP_STRB_W'(bus.pstrb_i) : '0;
            rdata_q   <= '0;
            slverr_q  <= !accept;
            abort_q   <= 1'b0;
          end
        end
        REQ: begin
          if (!bus.psel_i) abort_q <= 1'b1;
          if (bus.rsp_valid_i) begin
            rdata_q  <= cap.we ? '0 : bus.rdata_i;
            slverr_q <= bus.err_i;
          end else if (timeout) begin
            rdata_q  <= '0;
            slverr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef APB_COMPLETER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    logic [CNT_W-1:0] cnt;

    // Clears whenever outside REQ so every request starts from zero.
    always_ff @(posedge clk_i) begin
      if (rst_i || state != REQ) cnt <= '0;
      else if (!bus.rsp_valid_i) cnt <= cnt + 1'b1;
    end

    assign timeout = (state == REQ) && !bus.rsp_valid_i &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  assign timeout = 1'b0;
`endif

  assign bus.req_o     = (state == REQ);
  assign bus.we_o      = cap.we;
  assign bus.addr_o    = cap.addr[ADDR_WIDTH-1:0];
  assign bus.wdata_o   = cap.wdata[DATA_WIDTH-1:0];
  assign bus.be_o      = cap.be[STRB_W-1:0];
  assign bus.pready_o  = (state == RESP);
  assign bus.prdata_o  = bus.pready_o ? rdata_q : '0;
  assign bus.pslverr_o = bus.pready_o && slverr_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: vector table of APB transfers plus corner-case sequences.
module tb_apb_completer;
  import apb_completer_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [AW-1:0] BASE = 32'h0000_1000;
  localparam logic [AW:0]   MAP  = 33'h100;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  apb_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  apb_completer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .MAP_SIZE(MAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  int idle_bad = 0;
  logic prev_pready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // prdata/pslverr must be 0 without pready, and pready lasts one cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pready_o !== 1'b1 && (bus.prdata_o !== '0 || bus.pslverr_o !== 1'b0)) idle_bad++;
      if (prev_pready && bus.pready_o === 1'b1) idle_bad++;
    end
    prev_pready = (bus.pready_o === 1'b1);
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    int            waits;
    int            reqc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] be;
    logic          hold_bad;
    logic          timed_out;
  } res_t;

  task automatic idle_bus();
    bus.psel_i = 0; bus.penable_i = 0; bus.paddr_i = '0; bus.pwrite_i = 0;
    bus.pwdata_i = '0; bus.pstrb_i = '0; bus.rsp_valid_i = 0; bus.rdata_i = '0; bus.err_i = 0;
  endtask

  // Called just after a negedge in an IDLE cycle; returns just after the
  // negedge of the cycle following RESP, with the APB bus idle.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int delay, input logic [DW-1:0] rdata,
                          input logic err, output res_t res);
    logic done;
    res = '{default: '0};
    done = 0;
    bus.psel_i = 1; bus.penable_i = 0; bus.paddr_i = addr; bus.pwrite_i = wr;
    bus.pwdata_i = wdata; bus.pstrb_i = strb;
    @(negedge clk);
    bus.penable_i = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (bus.pready_o === 1'b1) begin
        res.rdata = bus.prdata_o;
        res.slverr = bus.pslverr_o;
        done = 1;
      end else begin
        res.waits++;
        if (bus.req_o === 1'b1) begin
          res.reqc++;
          if (res.reqc == 1) begin
            res.we = bus.we_o; res.addr = bus.addr_o; res.wdata = bus.wdata_o; res.be = bus.be_o;
          end else if (res.we !== bus.we_o || res.addr !== bus.addr_o ||
                       res.wdata !== bus.wdata_o || res.be !== bus.be_o) begin
            res.hold_bad = 1;
          end
          bus.rsp_valid_i = (res.reqc == delay + 1);
          bus.rdata_i = bus.rsp_valid_i ? rdata : DW'($urandom);
          bus.err_i = bus.rsp_valid_i ? err : 1'b0;
        end else begin
          bus.rsp_valid_i = 0;
        end
        @(negedge clk);
      end
    end
    res.timed_out = !done;
    bus.rsp_valid_i = 0; bus.err_i = 0;
    @(negedge clk);
    bus.psel_i = 0; bus.penable_i = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            delay;
    logic [DW-1:0] rdata;
    logic          err;
    logic [DW-1:0] exp_rdata;
    logic          exp_slverr;
    int            exp_waits;
    int            exp_reqc;
    logic [AW-1:0] exp_addr;
    logic [SW-1:0] exp_be;
  } vec_t;

  function automatic vec_t mk(input string name, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [SW-1:0] strb, input int delay,
                              input logic [DW-1:0] rdata, input logic err, input logic [DW-1:0] exp_rdata,
                              input logic exp_slverr, input int exp_waits, input int exp_reqc,
                              input logic [AW-1:0] exp_addr, input logic [SW-1:0] exp_be);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.delay = delay;
    v.rdata = rdata; v.err = err; v.exp_rdata = exp_rdata; v.exp_slverr = exp_slverr;
    v.exp_waits = exp_waits; v.exp_reqc = exp_reqc; v.exp_addr = exp_addr; v.exp_be = exp_be;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    res_t r;
    int   seen;
    int   reqn;
    logic flag;

    vecs[0] = mk("rd_p4",      0, 32'h1004, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1, 1, 32'h4,  4'h0);
    vecs[1] = mk("wr_p8_d5",   1, 32'h1008, 32'h12345678, 4'h3, 5, 32'h5555AAAA, 0, 32'h0,        0, 6, 6, 32'h8,  4'h3);
    vecs[2] = mk("rd_top",     0, 32'h1100, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,  4'h0);
    vecs[3] = mk("wr_misal",   1, 32'h1002, 32'hFFFF0000, 4'hF, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,  4'h0);
    vecs[4] = mk("rd_err",     0, 32'h100C, 32'h0,        4'h0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 2, 2, 32'hC,  4'h0);
    vecs[5] = mk("wr_strb0",   1, 32'h1010, 32'hA5A5A5A5, 4'h0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h10, 4'h0);
    vecs[6] = mk("wr_err_end", 1, 32'h10FC, 32'h0BADC0DE, 4'hF, 2, 32'h11111111, 1, 32'h0,        1, 3, 3, 32'hFC, 4'hF);
    vecs[7] = mk("rd_below",   0, 32'h0FFC, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,  4'h0);
    vecs[8] = mk("rd_high",    0, 32'hFFFFFFF0, 32'h0,    4'h0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,  4'h0);
    vecs[9] = mk("rd_base_d3", 0, 32'h1000, 32'h0,        4'h0, 3, 32'h00C0FFEE, 0, 32'h00C0FFEE, 0, 4, 4, 32'h0,  4'h0);

    // reset state
    idle_bus();
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst_req",    bus.req_o, 0);
    check("rst_pready", bus.pready_o, 0);
    check("rst_prdata", bus.prdata_o, 0);
    check("rst_slverr", bus.pslverr_o, 0);
    check("rst_we",     bus.we_o, 0);
    check("rst_addr",   bus.addr_o, 0);
    check("rst_be",     bus.be_o, 0);
    check("rst_state",  bus.dbg_state, IDLE);
    rst = 0;

    // table, applied back-to-back
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_rdata);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].delay,
               vecs[i].rdata, vecs[i].err, r);
      check({vecs[i].name, "_timeout"}, r.timed_out, 0);
      check({vecs[i].name, "_prdata"},  r.rdata, exp_q.pop_front());
      check({vecs[i].name, "_slverr"},  r.slverr, vecs[i].exp_slverr);
      check({vecs[i].name, "_waits"},   r.waits, vecs[i].exp_waits);
      check({vecs[i].name, "_reqc"},    r.reqc, vecs[i].exp_reqc);
      if (vecs[i].exp_reqc > 0) begin
        check({vecs[i].name, "_addr"}, r.addr, vecs[i].exp_addr);
        check({vecs[i].name, "_be"},   r.be, vecs[i].exp_be);
        check({vecs[i].name, "_we"},   r.we, vecs[i].wr);
        check({vecs[i].name, "_hold"}, r.hold_bad, 0);
        if (vecs[i].wr) check({vecs[i].name, "_wdata"}, r.wdata, vecs[i].wdata);
      end
    end

    // rsp_valid with no request pending is ignored
    bus.rsp_valid_i = 1; bus.rdata_i = 32'h77777777;
    flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.req_o !== 1'b0 || bus.pready_o !== 1'b0) flag = 1;
    end
    bus.rsp_valid_i = 0;
    check("stray_rsp_ignored", flag, 0);

    // reset in the middle of REQ
    bus.psel_i = 1; bus.penable_i = 0; bus.paddr_i = 32'h1020; bus.pwrite_i = 1;
    bus.pwdata_i = 32'h99999999; bus.pstrb_i = 4'hF;
    @(negedge clk);
    bus.penable_i = 1;
    check("midrst_req_before", bus.req_o, 1);
    rst = 1;
    @(negedge clk);
    check("midrst_req",    bus.req_o, 0);
    check("midrst_pready", bus.pready_o, 0);
    check("midrst_state",  bus.dbg_state, IDLE);
    check("midrst_we",     bus.we_o, 0);
    rst = 0;
    idle_bus();
    @(negedge clk);
    apb_xfer(0, 32'h1024, 32'h0, 4'h0, 1, 32'h13579BDF, 0, r);
    check("after_rst_prdata", r.rdata, 32'h13579BDF);
    check("after_rst_waits",  r.waits, 2);

    // initiator drops psel while the register side is busy
    bus.psel_i = 1; bus.penable_i = 0; bus.paddr_i = 32'h1028; bus.pwrite_i = 0;
    @(negedge clk);
    bus.penable_i = 1;
    check("drop_req_t1", bus.req_o, 1);
    bus.psel_i = 0; bus.penable_i = 0;
    @(negedge clk);
    check("drop_req_t2", bus.req_o, 1);
    bus.rsp_valid_i = 1; bus.rdata_i = 32'h24681357;
    @(negedge clk);
    bus.rsp_valid_i = 0;
    check("drop_req_t3",    bus.req_o, 0);
    check("drop_pready_t3", bus.pready_o, 0);
    check("drop_state_t3",  bus.dbg_state, IDLE);
    @(negedge clk);
    check("drop_pready_t4", bus.pready_o, 0);

    // register side never answers
`ifdef APB_COMPLETER_TIMEOUT_EN
    apb_xfer(0, 32'h102C, 32'h0, 4'h0, 1000, 32'h0, 0, r);
    check("to_done",   r.timed_out, 0);
    check("to_reqc",   r.reqc, TO);
    check("to_slverr", r.slverr, 1);
    check("to_prdata", r.rdata, 0);
    bus.rsp_valid_i = 1; bus.rdata_i = 32'h31313131;
    @(negedge clk);
    bus.rsp_valid_i = 0;
    check("to_late_rsp_pready", bus.pready_o, 0);
    check("to_late_rsp_state",  bus.dbg_state, IDLE);
`else
    bus.psel_i = 1; bus.penable_i = 0; bus.paddr_i = 32'h102C; bus.pwrite_i = 0;
    @(negedge clk);
    bus.penable_i = 1;
    seen = 0; reqn = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pready_o === 1'b1) seen++;
      if (bus.req_o === 1'b1) reqn++;
      @(negedge clk);
    end
    check("nto_pready_never", seen, 0);
    check("nto_req_held",     reqn, 100);
    bus.rsp_valid_i = 1; bus.rdata_i = 32'h600DF00D;
    @(negedge clk);
    bus.rsp_valid_i = 0;
    check("nto_final_pready", bus.pready_o, 1);
    check("nto_final_prdata", bus.prdata_o, 32'h600DF00D);
    @(negedge clk);
    bus.psel_i = 0; bus.penable_i = 0;
`endif

    repeat (2) @(negedge clk);
    check("idle_outputs_zero", idle_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
